conv1d_1st_mac: RTL and testbench
=================================

// Module: conv1d_1st_mac
// PURPOSE
//  Multiply-accumulate engine for the first CONV1D layer. Consumes one input sample per kernel tap
//  via valid/ready and drives Enable/Depth of the 6-channel weight RAM. Accumulates 6 channel sums,
//  then emits one shifted, ReLU'd, saturated result vector per KERNEL-sample window.
//  Sits directly downstream of the layer-1 weight RAM and upstream of the layer-1 output buffer.
// PARAMETERS
//  Bit_width   16  sample, weight and output width (signed)
//  KERNEL      8   taps per window; 1..32, must be <= weight RAM depth
//  ACC_W       40  signed accumulator width
//  FRAC_SHIFT  6   arithmetic right shift applied to the accumulator before saturation
//  RELU        1   1: negative results clamp to 0; 0: pass signed
// PORTS
//  CLK         in   1         clock; all logic posedge except the weight RAM, which reads on negedge
//  RST_N       in   1         asynchronous active-low reset
//  in_valid    in   1         in_data valid
//  in_ready    out  1         engine accepts a sample; = (state==ACC)
//  in_data     in   Bit_width signed sample for the current tap
//  Enable      out  1         weight RAM read enable
//  Depth       out  5         weight RAM tap address
//  w_0..w_5    in   Bit_width signed weights returned by the RAM (data_out_0..5)
//  out_valid   out  1         result vector valid
//  out_ready   in   1         downstream accepts the vector
//  out_0..5    out  Bit_width signed channel results
// BEHAVIOUR
//  Reset (async, RST_N=0):
//   - state=ACC, tap=0, all accumulators 0, Enable=0, Depth=0, out_valid=0, out_0..5=0.
//   - in_ready=0 while RST_N=0.
//   - A partial window is discarded.
//  States:
//   - ACC: in_ready=1.
//     - On each posedge with in_valid & in_ready: sample_q<=in_data, Depth<=tap, Enable<=1, pend<=1, tap<=tap+1.
//     - Without a handshake: Enable<=0, pend<=0; Depth holds.
//     - When the accepted tap == KERNEL-1: tap<=0, go DRAIN.
//   - DRAIN: in_ready=0, Enable<=0; the final pending MAC occurs this edge; go SAT.
//   - SAT: out_c <= sat(relu(acc_c >>> FRAC_SHIFT)); out_valid<=1; go OUT.
//   - OUT: out_valid=1; outputs held stable.
//     - On out_valid & out_ready: out_valid<=0, all acc<=0, go ACC.
//     - out_0..5 keep their value until the next SAT.
//  MAC timing:
//   - The weight RAM registers w_c at the negedge after Depth/Enable change.
//   - At the next posedge, if pend: acc_c <= acc_c + sample_q*w_c.
//   - Product is a 2*Bit_width signed full product, sign-extended to ACC_W; no overflow check inside ACC_W.
//  Latency: last sample accepted at edge n -> final MAC at n+1 -> out_valid high after edge n+2.
//  Throughput: one sample/cycle; gaps in in_valid insert bubbles with Enable=0 and leave sums unchanged.
//  Saturation: clamp to [-2^(Bit_width-1), 2^(Bit_width-1)-1] after shift (ReLU first when RELU=1).
//  Backpressure: while OUT and out_ready=0, in_ready stays 0; no new window starts.
//  Simultaneous: the out handshake at edge m makes in_ready=1 after edge m; no sample is taken at edge m.
// TESTING (bench: negedge weight stub with w_c[t]=(c+1)*(t+1) unless stated; default params)
//  1 8 samples of 64, back-to-back
//    -> out_0..5 = 36,72,108,144,180,216
//    -> out_valid rises 2 edges after the last accept
//  2 8 samples of -64, RELU=1
//    -> all outputs 0
//    -> with RELU=0: -36,-72,...,-216
//  3 samples 32767, stub w=32767 for all taps
//    -> all outputs 32767 (saturated)
//    -> samples -32768 with w=32767, RELU=0 -> all outputs -32768
//  4 out_ready=0 for 10 cycles
//    -> outputs and out_valid stable, in_ready=0
//    -> raise out_ready: in_ready=1 the next cycle, acc cleared
//  5 in_valid alternating 1/0 over 8 samples
//    -> Enable low on bubble cycles; Depth sequence 0..7
//    -> results identical to test 1
//  6 RST_N pulsed low after 4 accepted taps
//    -> all outputs/Enable/out_valid 0 immediately
//    -> the next full window gives test 1 values

Source files
------------

// File: rtl/conv1d_1st_mac.sv
// rtl/conv1d_1st_mac.sv - first CONV1D layer MAC engine, 6 channels over a KERNEL-tap window
// Weight RAM answers on the negedge after Enable/Depth, so each MAC lands one posedge after its accept.
module conv1d_1st_mac #(
  parameter int Bit_width  = 16,
  parameter int KERNEL     = 8,
  parameter int ACC_W      = 40,
  parameter int FRAC_SHIFT = 6,
  parameter int RELU       = 1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [Bit_width-1:0] in_data,
  output logic                        Enable,
  output logic [4:0]                  Depth,
  input  logic signed [Bit_width-1:0] w_0,
  input  logic signed [Bit_width-1:0] w_1,
  input  logic signed [Bit_width-1:0] w_2,
  input  logic signed [Bit_width-1:0] w_3,
  input  logic signed [Bit_width-1:0] w_4,
  input  logic signed [Bit_width-1:0] w_5,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [Bit_width-1:0] out_0,
  output logic signed [Bit_width-1:0] out_1,
  output logic signed [Bit_width-1:0] out_2,
  output logic signed [Bit_width-1:0] out_3,
  output logic signed [Bit_width-1:0] out_4,
  output logic signed [Bit_width-1:0] out_5
);

  typedef enum logic [1:0] {ACC, DRAIN, SAT, OUT} state_t;

  localparam logic [4:0]              LAST = 5'(KERNEL - 1);
  localparam logic signed [ACC_W-1:0] SMAX = (ACC_W'(1) <<< (Bit_width - 1)) - 1;
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - 1;

  state_t                        state, state_nxt;
  logic [4:0]                    tap;
  logic                          pend;
  logic signed [Bit_width-1:0]   sample_q;
  logic signed [Bit_width-1:0]   w_arr  [6];
  logic signed [2*Bit_width-1:0] prod   [6];
  logic signed [ACC_W-1:0]       prod_x [6];
  logic signed [ACC_W-1:0]       acc    [6];
  logic signed [Bit_width-1:0]   out_r  [6];

  assign w_arr[0] = w_0;
  assign w_arr[1] = w_1;
  assign w_arr[2] = w_2;
  assign w_arr[3] = w_3;
  assign w_arr[4] = w_4;
  assign w_arr[5] = w_5;

  assign out_0 = out_r[0];
  assign out_1 = out_r[1];
  assign out_2 = out_r[2];
  assign out_3 = out_r[3];
  assign out_4 = out_r[4];
  assign out_5 = out_r[5];

  assign in_ready = RST_N && (state == ACC);

  always_comb begin
    for (int c = 0; c < 6; c++) begin
      prod[c]   = sample_q * w_arr[c];
      prod_x[c] = {{(ACC_W - 2*Bit_width){prod[c][2*Bit_width-1]}}, prod[c]};
    end
  end

  function automatic logic signed [Bit_width-1:0] shift_relu_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_SHIFT;
    if (RELU != 0 && s < 0) s = '0;
    if (s > SMAX)      shift_relu_sat = SMAX[Bit_width-1:0];
    else if (s < SMIN) shift_relu_sat = SMIN[Bit_width-1:0];
    else               shift_relu_sat = s[Bit_width-1:0];
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (in_valid && tap == LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = SAT;
      SAT:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tap       <= '0;
      pend      <= 1'b0;
      sample_q  <= '0;
      Enable    <= 1'b0;
      Depth     <= '0;
      out_valid <= 1'b0;
      for (int c = 0; c < 6; c++) begin
        acc[c]   <= '0;
        out_r[c] <= '0;
      end
    end else begin
      // The MAC for the previous accept uses the weights latched on the intervening negedge.
      if (pend) begin
        for (int c = 0; c < 6; c++) acc[c] <= acc[c] + prod_x[c];
      end
      case (state)
        ACC: begin
          if (in_valid) begin
            sample_q <= in_data;
            Depth    <= tap;
            Enable   <= 1'b1;
            pend     <= 1'b1;
            tap      <= (tap == LAST) ? 5'd0 : tap + 5'd1;
          end else begin
            Enable <= 1'b0;
            pend   <= 1'b0;
          end
        end
        DRAIN: begin
          Enable <= 1'b0;
          pend   <= 1'b0;
        end
        SAT: begin
          for (int c = 0; c < 6; c++) out_r[c] <= shift_relu_sat(acc[c]);
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            for (int c = 0; c < 6; c++) acc[c] <= '0;
          end
        end
        default: begin
          Enable <= 1'b0;
          pend   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_1st_mac.sv
// tb/tb_conv1d_1st_mac.sv - directed bench for conv1d_1st_mac
// Two instances share stimulus: dut (RELU=1) and dut_nr (RELU=0).
module tb_conv1d_1st_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, in_valid, out_ready;
  logic signed [15:0] in_data;
  logic               in_ready, in_ready_nr, en, en_nr, ov, ov_nr;
  logic [4:0]         depth, depth_nr;
  logic signed [15:0] w  [6];
  logic signed [15:0] o1 [6];
  logic signed [15:0] o0 [6];
  bit                 sat_mode = 1'b0;
  int                 checks = 0;
  int                 errors = 0;

  conv1d_1st_mac #(.RELU(1)) dut (
    .CLK(clk), .RST_N(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .Enable(en), .Depth(depth),
    .w_0(w[0]), .w_1(w[1]), .w_2(w[2]), .w_3(w[3]), .w_4(w[4]), .w_5(w[5]),
    .out_valid(ov), .out_ready(out_ready),
    .out_0(o1[0]), .out_1(o1[1]), .out_2(o1[2]), .out_3(o1[3]), .out_4(o1[4]), .out_5(o1[5])
  );

  conv1d_1st_mac #(.RELU(0)) dut_nr (
    .CLK(clk), .RST_N(rst_n), .in_valid(in_valid), .in_ready(in_ready_nr), .in_data(in_data),
    .Enable(en_nr), .Depth(depth_nr),
    .w_0(w[0]), .w_1(w[1]), .w_2(w[2]), .w_3(w[3]), .w_4(w[4]), .w_5(w[5]),
    .out_valid(ov_nr), .out_ready(out_ready),
    .out_0(o0[0]), .out_1(o0[1]), .out_2(o0[2]), .out_3(o0[3]), .out_4(o0[4]), .out_5(o0[5])
  );

  // Negedge weight RAM: w_c[t] = (c+1)*(t+1), or 32767 everywhere in saturation mode.
  always @(negedge clk) begin
    if (en) begin
      for (int c = 0; c < 6; c++)
        w[c] <= sat_mode ? 16'sd32767 : 16'((c + 1) * (int'(depth) + 1));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_window(input logic signed [15:0] s, input bit gap);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL win_in_ready tap %0d: got %b want 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_data  = s;
      tick();
      checks++;
      if (en !== 1'b1 || depth !== 5'(i)) begin
        errors++;
        $display("FAIL accept_en_depth tap %0d: got en=%b depth=%0d want en=1 depth=%0d", i, en, depth, i);
      end
      in_valid = 1'b0;
      if (gap && i < 7) begin
        tick();
        checks++;
        if (en !== 1'b0 || depth !== 5'(i)) begin
          errors++;
          $display("FAIL bubble_en_depth tap %0d: got en=%b depth=%0d want en=0 depth=%0d", i, en, depth, i);
        end
      end
    end
    checks++;
    if (ov !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL lat_edge0: got ov=%b in_ready=%b want 0 0", ov, in_ready);
    end
    tick();
    checks++;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL lat_edge1: got ov=%b want 0", ov);
    end
    tick();
    checks++;
    if (ov !== 1'b1 || ov_nr !== 1'b1) begin
      errors++;
      $display("FAIL lat_edge2: got ov=%b ov_nr=%b want 1 1", ov, ov_nr);
    end
  endtask

  task automatic finish_vector;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (ov !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL out_handshake: got ov=%b in_ready=%b want 0 1", ov, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #23;
    checks++;
    if (in_ready !== 1'b0 || ov !== 1'b0 || en !== 1'b0 || depth !== 5'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got in_ready=%b ov=%b en=%b depth=%0d want 0 0 0 0", in_ready, ov, en, depth);
    end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o1[c] !== 16'sd0) begin
        errors++;
        $display("FAIL reset_out%0d: got %0d want 0", c, o1[c]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    send_window(16'sd64, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o1[c] !== 16'(36 * (c + 1)) || o0[c] !== 16'(36 * (c + 1))) begin
        errors++;
        $display("FAIL basic_out%0d: got %0d/%0d want %0d", c, o1[c], o0[c], 36 * (c + 1));
      end
    end
  endtask

  task automatic test_back_to_back;
    in_valid  = 1'b1;
    in_data   = 16'sd64;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (ov !== 1'b0 || in_ready !== 1'b1 || en !== 1'b0 || depth !== 5'd7) begin
      errors++;
      $display("FAIL b2b_no_take: got ov=%b in_ready=%b en=%b depth=%0d want 0 1 0 7", ov, in_ready, en, depth);
    end
    send_window(16'sd64, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o1[c] !== 16'(36 * (c + 1))) begin
        errors++;
        $display("FAIL b2b_out%0d: got %0d want %0d", c, o1[c], 36 * (c + 1));
      end
    end
    finish_vector();
  endtask

  task automatic test_negative;
    send_window(-16'sd64, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o1[c] !== 16'sd0 || o0[c] !== 16'(-36 * (c + 1))) begin
        errors++;
        $display("FAIL neg_out%0d: got relu=%0d raw=%0d want 0 %0d", c, o1[c], o0[c], -36 * (c + 1));
      end
    end
    finish_vector();
  endtask

  task automatic test_saturation;
    sat_mode = 1'b1;
    send_window(16'sd32767, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o1[c] !== 16'sd32767 || o0[c] !== 16'sd32767) begin
        errors++;
        $display("FAIL sat_pos_out%0d: got %0d/%0d want 32767", c, o1[c], o0[c]);
      end
    end
    finish_vector();
    send_window(-16'sd32768, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o0[c] !== -16'sd32768 || o1[c] !== 16'sd0) begin
        errors++;
        $display("FAIL sat_neg_out%0d: got raw=%0d relu=%0d want -32768 0", c, o0[c], o1[c]);
      end
    end
    finish_vector();
    sat_mode = 1'b0;
  endtask

  task automatic test_backpressure;
    send_window(16'sd64, 1'b0);
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (ov !== 1'b1 || in_ready !== 1'b0 || o1[5] !== 16'sd216 || o1[0] !== 16'sd36) begin
        errors++;
        $display("FAIL bp_hold cyc %0d: got ov=%b in_ready=%b o0=%0d o5=%0d want 1 0 36 216", k, ov, in_ready, o1[0], o1[5]);
      end
    end
    in_valid = 1'b0;
    finish_vector();
    send_window(16'sd64, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o1[c] !== 16'(36 * (c + 1))) begin
        errors++;
        $display("FAIL bp_cleared_out%0d: got %0d want %0d", c, o1[c], 36 * (c + 1));
      end
    end
    finish_vector();
  endtask

  task automatic test_bubbles;
    send_window(16'sd64, 1'b1);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o1[c] !== 16'(36 * (c + 1))) begin
        errors++;
        $display("FAIL bubble_out%0d: got %0d want %0d", c, o1[c], 36 * (c + 1));
      end
    end
    finish_vector();
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'sd64;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (en !== 1'b0 || ov !== 1'b0 || in_ready !== 1'b0 || depth !== 5'd0) begin
      errors++;
      $display("FAIL arst_ctrl: got en=%b ov=%b in_ready=%b depth=%0d want 0 0 0 0", en, ov, in_ready, depth);
    end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o1[c] !== 16'sd0) begin
        errors++;
        $display("FAIL arst_out%0d: got %0d want 0", c, o1[c]);
      end
    end
    #2;
    rst_n = 1'b1;
    tick();
    send_window(16'sd64, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o1[c] !== 16'(36 * (c + 1))) begin
        errors++;
        $display("FAIL arst_window_out%0d: got %0d want %0d", c, o1[c], 36 * (c + 1));
      end
    end
    finish_vector();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_negative();
    test_saturation();
    test_bubbles();
    test_backpressure();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
